// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 8 requesters with decoded one-hot grant
// and a hold-time limit that preempts a grant after HOLD_MAX cycles.
//
// Ports:
//   clk_i        clock, all state updates on posedge
//   reset_i      synchronous active-high reset
//   req_i[7:0]   request vector, bit i = requester i
//   done_i       current owner finished (only looked at in GRANT)
//   gnt_o[7:0]   one-hot grant, zero when no grant is active
//   gnt_idx_o    index of current or last winner
//   gnt_valid_o  grant active
//   preempt_o    1-cycle pulse when a grant ended by timeout
module rr_decoder_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       preempt_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [3:0] HOLD_LAST =
    4'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] hold_q, hold_d;
  logic       preempt_q, preempt_d;

  logic [2:0] win;
  logic       win_vld;
  logic       owner_req;
  logic       timeout;

  // Scan from ptr upward with wrap; the loop
  // runs from the farthest offset down so the
  // closest set bit to ptr is the last written.
  always_comb begin
    logic [2:0] cand;
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (req_i[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign owner_req = req_i[idx_q];
  assign timeout   = (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          idx_d   = win;
          hold_d  = '0;
        end
      end
      GRANT: begin
        // done beats timeout, so a
        // simultaneous done never preempts.
        if (done_i || !owner_req) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
          hold_d  = '0;
        end else if (timeout) begin
          state_d   = IDLE;
          ptr_d     = idx_q + 3'd1;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt_valid_o = (state_q == GRANT);
  assign gnt_idx_o   = idx_q;
  assign preempt_o   = preempt_q;
  assign gnt_o       = gnt_valid_o
                     ? (8'b1 << idx_q)
                     : 8'b0;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed self-checking bench for rr_decoder_arbiter
// with hand-computed grant sequences.
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_decoder_arbiter #(.HOLD_MAX(4)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .req_i      (req),
    .done_i     (done),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .preempt_o  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    done  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_grant(
    input string      tag,
    input logic [2:0] idx
  );
    logic [7:0] oh;
    oh = 8'b1 << idx;
    check({tag, ".valid"}, 32'(gnt_valid), 32'd1);
    check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    check({tag, ".gnt"}, 32'(gnt), 32'(oh));
  endtask

  task automatic chk_idle(
    input string tag,
    input logic  pre
  );
    check({tag, ".valid"}, 32'(gnt_valid), 32'd0);
    check({tag, ".gnt"}, 32'(gnt), 32'd0);
    check({tag, ".pre"}, 32'(preempt), 32'(pre));
  endtask

  initial begin
    logic [2:0] order [9];
    reset = 1'b0;
    req   = '0;
    done  = 1'b0;
    step();

    // 1: reset state, then single request
    do_reset();
    chk_idle("rst", 1'b0);
    check("rst.idx", 32'(gnt_idx), 32'd0);
    req = 8'b0000_0100;
    step();
    chk_grant("t1", 3'd2);

    // 2: full request, done every grant
    do_reset();
    req   = 8'hFF;
    order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
              3'd5, 3'd6, 3'd7, 3'd0};
    step();
    for (int i = 0; i < 9; i++) begin
      chk_grant($sformatf("t2.g%0d", i),
                order[i]);
      done = 1'b1;
      step();
      done = 1'b0;
      chk_idle($sformatf("t2.b%0d", i), 1'b0);
      step();
    end

    // 3: hold timeout preempts after 4 cycles
    do_reset();
    req = 8'b0010_0000;
    step();
    for (int c = 0; c < 4; c++) begin
      chk_grant($sformatf("t3.c%0d", c), 3'd5);
      step();
    end
    chk_idle("t3.rel", 1'b1);
    step();
    chk_grant("t3.re", 3'd5);
    check("t3.pre1", 32'(preempt), 32'd0);

    // 4: owner drops request, ptr moves to 4
    do_reset();
    req = 8'b0000_1000;
    step();
    chk_grant("t4.g3", 3'd3);
    req = 8'b0100_1000;
    step();
    chk_grant("t4.hold", 3'd3);
    req = 8'b0100_0001;
    step();
    chk_idle("t4.rel", 1'b0);
    step();
    chk_grant("t4.g6", 3'd6);

    // 5: reset mid-grant clears ptr
    do_reset();
    req = 8'b0000_1000;
    step();
    chk_grant("t5.g3", 3'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("t5.rst", 1'b0);
    check("t5.idx", 32'(gnt_idx), 32'd0);
    req = 8'h81;
    step();
    chk_grant("t5.g0", 3'd0);

    // 6: done on timeout cycle, done in IDLE
    do_reset();
    req = 8'b0000_0010;
    step();
    chk_grant("t6.g1", 3'd1);
    step();
    step();
    step();
    chk_grant("t6.last", 3'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_idle("t6.rel", 1'b0);
    step();
    chk_grant("t6.re", 3'd1);
    req = 8'b0;
    step();
    chk_idle("t6.drop", 1'b0);
    done = 1'b1;
    step();
    chk_idle("t6.id1", 1'b0);
    step();
    chk_idle("t6.id2", 1'b0);
    check("t6.idxk", 32'(gnt_idx), 32'd1);
    done = 1'b0;
    req  = 8'b0000_0110;
    step();
    chk_grant("t6.g2", 3'd2);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
